// File: rtl/apb_mem_slave_ws.sv
// ============================================================================
// Module   : apb_mem_slave_ws
// Brief    : APB4 memory slave with byte strobes, configurable wait states and
//            address, alignment and strobe error checking.
//            Optional macro APB_MEM_PROT_CHECK_EN turns unprivileged writes into errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_mem_slave_ws #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0000_3000),
    parameter int                    WAIT_STATES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [2:0]              PPROT,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam int                    OFF_BITS  = $clog2(BYTES);
    localparam int                    IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   WIN_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [3:0]            WS        = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    err_q;
    logic                    write_q;
    logic [IDX_W-1:0]        idx_q;
    logic [BYTES-1:0]        strb_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   w_off;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_prot_err;
    logic                    w_err;
    logic                    w_setup;
    logic                    w_ready;
    logic                    w_commit;

    assign w_off = PADDR - BASE_ADDR;
    assign w_idx = IDX_W'(w_off >> OFF_BITS);

`ifdef APB_MEM_PROT_CHECK_EN
    assign w_prot_err = PWRITE && !PPROT[0];
`else
    logic w_unused_pprot;
    assign w_unused_pprot = ^PPROT;
    assign w_prot_err     = 1'b0;
`endif

    // Explicit below-base compare catches the modular wrap of w_off.
    assign w_err = (PADDR < BASE_ADDR)
                 | ({1'b0, w_off} >= WIN_BYTES)
                 | ((w_off & LANE_MASK) != '0)
                 | (!PWRITE && (PSTRB != '0))
                 | w_prot_err;

    assign w_setup  = (state_q == IDLE) && PSEL && !PENABLE;
    assign w_ready  = (state_q == ACCESS) && (cnt_q == WS);
    assign w_commit = w_ready && PSEL && write_q && !err_q;

    assign PREADY  = w_ready;
    assign PSLVERR = err_q & w_ready;
    assign PRDATA  = prdata_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (!PSEL || (cnt_q == WS)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            strb_q   <= '0;
            wdata_q  <= '0;
            prdata_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_setup) begin
                err_q   <= w_err;
                write_q <= PWRITE;
                idx_q   <= w_idx;
                strb_q  <= PSTRB;
                wdata_q <= PWDATA;
                if (!PWRITE) begin
                    prdata_q <= w_err ? '0 : mem_q[w_idx];
                end
            end
            if (w_commit) begin
                for (int k = 0; k < BYTES; k++) begin
                    if (strb_q[k]) begin
                        mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
